// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Also supplies default address/data widths when the build does not define them.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] MEM_BYT_B  = 3'b000;
  localparam logic [2:0] MEM_BYT_H  = 3'b001;
  localparam logic [2:0] MEM_BYT_W  = 3'b010;
  localparam logic [2:0] MEM_BYT_BU = 3'b100;
  localparam logic [2:0] MEM_BYT_HU = 3'b101;

  typedef logic [3:0] lane_mask_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend, store replication/strobes, misalign flag.
// Misalign detection is built only with LSU_MISALIGN_CHECK_EN defined.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        i_byt,
  input  logic [1:0]        i_addr_lo,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [DATA_W-1:0] i_rs2,
  output logic [DATA_W-1:0] o_load_res,
  output logic [DATA_W-1:0] o_wdata,
  output lane_mask_t        o_wmask,
  output logic              o_misalign
);

  logic              w_is_b;
  logic              w_is_h;
  logic [DATA_W-1:0] w_shift_b;
  logic [DATA_W-1:0] w_shift_h;

  assign w_is_b    = (i_byt == MEM_BYT_B) || (i_byt == MEM_BYT_BU);
  assign w_is_h    = (i_byt == MEM_BYT_H) || (i_byt == MEM_BYT_HU);
  // Half accesses only look at addr[1], so a stray addr[0] never splits a half.
  assign w_shift_b = i_rdata >> {i_addr_lo, 3'b000};
  assign w_shift_h = i_rdata >> {i_addr_lo[1], 4'b0000};

  always_comb begin
    o_load_res = i_rdata;
    case (i_byt)
      MEM_BYT_B:  o_load_res = {{(DATA_W-8){w_shift_b[7]}}, w_shift_b[7:0]};
      MEM_BYT_BU: o_load_res = {{(DATA_W-8){1'b0}}, w_shift_b[7:0]};
      MEM_BYT_H:  o_load_res = {{(DATA_W-16){w_shift_h[15]}}, w_shift_h[15:0]};
      MEM_BYT_HU: o_load_res = {{(DATA_W-16){1'b0}}, w_shift_h[15:0]};
      default:    o_load_res = i_rdata;
    endcase
  end

  always_comb begin
    o_wdata = i_rs2;
    o_wmask = 4'hF;
    if (w_is_b) begin
      o_wdata = {(DATA_W/8){i_rs2[7:0]}};
      o_wmask = 4'b0001 << i_addr_lo;
    end else if (w_is_h) begin
      o_wdata = {(DATA_W/16){i_rs2[15:0]}};
      o_wmask = 4'b0011 << {i_addr_lo[1], 1'b0};
    end
  end

`ifdef LSU_MISALIGN_CHECK_EN
  assign o_misalign = (w_is_h && i_addr_lo[0]) ||
                      (!w_is_b && !w_is_h && (i_addr_lo != 2'b00));
`else
  assign o_misalign = 1'b0;
`endif

endmodule

// File: rtl/lsu.sv
// Load/store unit between EXU and WBU: one memory transaction in flight, aligned load result.
// Optional misaligned-access trap port enabled by LSU_MISALIGN_CHECK_EN.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = `ADDR_WIDTH,
  parameter int DATA_W = `DATA_WIDTH
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sys_valid,
  output logic              o_sys_ready,
  input  logic              i_idu_ctr_mem_rd_en,
  input  logic              i_idu_ctr_mem_wr_en,
  input  logic [2:0]        i_idu_ctr_mem_byt,
  input  logic [DATA_W-1:0] i_exu_res,
  input  logic [DATA_W-1:0] i_gpr_rd_data_2,
  output logic              o_mem_req_valid,
  input  logic              i_mem_req_ready,
  output logic              o_mem_req_wr,
  output logic [ADDR_W-1:0] o_mem_req_addr,
  output logic [DATA_W-1:0] o_mem_req_wdata,
  output lane_mask_t        o_mem_req_wmask,
  input  logic              i_mem_rsp_valid,
  output logic              o_mem_rsp_ready,
  input  logic [DATA_W-1:0] i_mem_rsp_rdata,
  output logic              o_sys_valid,
  input  logic              i_sys_ready,
`ifdef LSU_MISALIGN_CHECK_EN
  output logic              o_lsu_misalign,
`endif
  output logic [DATA_W-1:0] o_lsu_res
);

  lsu_state_e        r_state;
  lsu_state_e        w_next;
  logic [2:0]        r_byt;
  logic [1:0]        r_addr_lo;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wr;
  logic [DATA_W-1:0] r_wdata;
  lane_mask_t        r_wmask;
  logic [DATA_W-1:0] r_res;
  logic              w_accept;
  logic              w_mem;
  logic              w_mis_go;
  logic              w_idle;
  logic [2:0]        w_byt;
  logic [1:0]        w_addr_lo;
  logic [DATA_W-1:0] w_load_res;
  logic [DATA_W-1:0] w_wdata;
  lane_mask_t        w_wmask;
  logic              w_mis;

  assign w_idle    = (r_state == S_IDLE);
  assign w_accept  = w_idle && i_sys_valid;
  assign w_mem     = i_idu_ctr_mem_rd_en || i_idu_ctr_mem_wr_en;
  assign w_mis_go  = w_mem && w_mis;
  // Align unit sees the incoming instruction while idle, the captured one afterwards.
  assign w_byt     = w_idle ? i_idu_ctr_mem_byt : r_byt;
  assign w_addr_lo = w_idle ? i_exu_res[1:0] : r_addr_lo;

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .i_byt      (w_byt),
    .i_addr_lo  (w_addr_lo),
    .i_rdata    (i_mem_rsp_rdata),
    .i_rs2      (i_gpr_rd_data_2),
    .o_load_res (w_load_res),
    .o_wdata    (w_wdata),
    .o_wmask    (w_wmask),
    .o_misalign (w_mis)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next          = r_state;
    o_sys_ready     = 1'b0;
    o_mem_req_valid = 1'b0;
    o_mem_rsp_ready = 1'b0;
    o_sys_valid     = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_sys_ready = 1'b1;
        if (i_sys_valid) w_next = (w_mem && !w_mis_go) ? S_REQ : S_DONE;
      end
      S_REQ: begin
        o_mem_req_valid = 1'b1;
        if (i_mem_req_ready) w_next = r_wr ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        o_mem_rsp_ready = 1'b1;
        if (i_mem_rsp_valid) w_next = S_DONE;
      end
      S_DONE: begin
        o_sys_valid = 1'b1;
        if (i_sys_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Transaction registers; cleared by reset so every output reads 0 afterwards.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_byt     <= 3'b000;
      r_addr_lo <= 2'b00;
      r_addr    <= '0;
      r_wr      <= 1'b0;
      r_wdata   <= '0;
      r_wmask   <= '0;
      r_res     <= '0;
    end else if (w_accept) begin
      r_byt     <= i_idu_ctr_mem_byt;
      r_addr_lo <= i_exu_res[1:0];
      r_addr    <= {i_exu_res[ADDR_W-1:2], 2'b00};
      r_wr      <= i_idu_ctr_mem_wr_en;
      r_wdata   <= w_wdata;
      r_wmask   <= i_idu_ctr_mem_wr_en ? w_wmask : 4'b0000;
      r_res     <= '0;
    end else if ((r_state == S_WAIT) && i_mem_rsp_valid) begin
      r_res     <= w_load_res;
    end
  end

`ifdef LSU_MISALIGN_CHECK_EN
  logic r_misalign;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_misalign <= 1'b0;
    else if (w_accept) r_misalign <= w_mis_go;
  end

  assign o_lsu_misalign = r_misalign;
`endif

  assign o_mem_req_wr    = r_wr;
  assign o_mem_req_addr  = r_addr;
  assign o_mem_req_wdata = r_wdata;
  assign o_mem_req_wmask = r_wmask;
  assign o_lsu_res       = r_res;

endmodule

// File: tb/tb_lsu.sv
// Directed testbench for lsu: bench-driven memory/WBU with hand-computed expectations.
// Build with LSU_MISALIGN_CHECK_EN defined to exercise the misalign trap.
`timescale 1ns/1ps
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sys_valid_i, sys_ready_o, rd_en, wr_en;
  logic [2:0]  byt;
  logic [31:0] exu_res, rs2;
  logic        req_valid, req_ready, req_wr;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wmask;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        sys_valid_o, sys_ready_i;
  logic [31:0] lsu_res;
  logic        lsu_mis;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_sys_valid         (sys_valid_i),
    .o_sys_ready         (sys_ready_o),
    .i_idu_ctr_mem_rd_en (rd_en),
    .i_idu_ctr_mem_wr_en (wr_en),
    .i_idu_ctr_mem_byt   (byt),
    .i_exu_res           (exu_res),
    .i_gpr_rd_data_2     (rs2),
    .o_mem_req_valid     (req_valid),
    .i_mem_req_ready     (req_ready),
    .o_mem_req_wr        (req_wr),
    .o_mem_req_addr      (req_addr),
    .o_mem_req_wdata     (req_wdata),
    .o_mem_req_wmask     (req_wmask),
    .i_mem_rsp_valid     (rsp_valid),
    .o_mem_rsp_ready     (rsp_ready),
    .i_mem_rsp_rdata     (rsp_rdata),
    .o_sys_valid         (sys_valid_o),
    .i_sys_ready         (sys_ready_i),
`ifdef LSU_MISALIGN_CHECK_EN
    .o_lsu_misalign      (lsu_mis),
`endif
    .o_lsu_res           (lsu_res)
  );

  // Observations from the most recent run_op
  logic [31:0] ob_res, ob_addr, ob_wdata;
  logic [3:0]  ob_wmask;
  logic        ob_wr, ob_stable, ob_timeout, ob_mis, ob_post_ready, ob_post_valid;
  int          ob_cyc, ob_reqvcnt, ob_vcnt, ob_nreq;

  task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data2,
                        input logic [31:0] mem_word, input int req_stall, input int sys_stall);
    int   rq_wait = 0;
    int   sy_wait = 0;
    logic rsp_pend = 1'b0;
    logic seen_req = 1'b0;
    logic seen_val = 1'b0;
    logic done = 1'b0;
    ob_res = '0; ob_addr = '0; ob_wdata = '0; ob_wmask = '0; ob_wr = 1'b0;
    ob_stable = 1'b1; ob_timeout = 1'b1; ob_mis = 1'b0;
    ob_post_ready = 1'b0; ob_post_valid = 1'b1;
    ob_cyc = 0; ob_reqvcnt = 0; ob_vcnt = 0; ob_nreq = 0;
    @(negedge clk);
    sys_valid_i = 1'b1; rd_en = rd; wr_en = wr; byt = f3; exu_res = addr; rs2 = data2;
    @(posedge clk);
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      sys_valid_i = 1'b0; rd_en = 1'b0; wr_en = 1'b0; exu_res = '0; rs2 = '0;
      req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0; sys_ready_i = 1'b0;
      if (done) begin
        ob_post_ready = sys_ready_o;
        ob_post_valid = sys_valid_o;
        ob_timeout = 1'b0;
        break;
      end
      if (req_valid) begin
        ob_reqvcnt++;
        if (!seen_req) begin
          seen_req = 1'b1; ob_addr = req_addr; ob_wdata = req_wdata;
          ob_wmask = req_wmask; ob_wr = req_wr;
        end else if ({req_addr, req_wdata, req_wmask, req_wr} !==
                     {ob_addr, ob_wdata, ob_wmask, ob_wr}) begin
          ob_stable = 1'b0;
        end
        if (rq_wait < req_stall) rq_wait++;
        else begin
          req_ready = 1'b1; ob_nreq++;
          if (!req_wr) rsp_pend = 1'b1;
        end
      end else if (rsp_ready && rsp_pend) begin
        rsp_valid = 1'b1; rsp_rdata = mem_word; rsp_pend = 1'b0;
      end else if (sys_valid_o) begin
        ob_vcnt++;
        if (!seen_val) begin
          seen_val = 1'b1; ob_cyc = cyc; ob_res = lsu_res;
`ifdef LSU_MISALIGN_CHECK_EN
          ob_mis = lsu_mis;
`endif
        end else if (lsu_res !== ob_res) begin
          ob_stable = 1'b0;
        end
        if (sy_wait < sys_stall) sy_wait++;
        else begin
          sys_ready_i = 1'b1; done = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({sys_ready_o, req_valid, rsp_ready, sys_valid_o} !== 4'b1000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 1000", {sys_ready_o, req_valid, rsp_ready, sys_valid_o});
    end
    checks++;
    if ({lsu_res, req_addr, req_wdata, req_wmask, req_wr} !== 101'd0) begin
      errors++; $display("FAIL reset_data: res=%h addr=%h wdata=%h wmask=%b wr=%b expected all 0",
                         lsu_res, req_addr, req_wdata, req_wmask, req_wr);
    end
  endtask

  task automatic test_lw();
    run_op(1'b1, 1'b0, MEM_BYT_W, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
    checks++;
    if (ob_timeout !== 1'b0) begin errors++; $display("FAIL lw_timeout: got %b expected 0", ob_timeout); end
    checks++;
    if (ob_res !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_res: got %h expected DEADBEEF", ob_res); end
    checks++;
    if (ob_cyc !== 3) begin errors++; $display("FAIL lw_latency: got %0d expected 3", ob_cyc); end
    checks++;
    if ({ob_addr, ob_wr, ob_wmask} !== {32'h100, 1'b0, 4'b0000}) begin
      errors++; $display("FAIL lw_req: addr=%h wr=%b wmask=%b expected 100/0/0000", ob_addr, ob_wr, ob_wmask);
    end
    checks++;
    if ({ob_post_ready, ob_post_valid, ob_mis} !== 3'b100) begin
      errors++; $display("FAIL lw_post: ready/valid/mis=%b expected 100", {ob_post_ready, ob_post_valid, ob_mis});
    end
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3  [5] = '{MEM_BYT_B, MEM_BYT_BU, MEM_BYT_HU, MEM_BYT_H, MEM_BYT_B};
    logic [31:0] ad  [5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101};
    logic [31:0] exp [5] = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF, 32'hFFFF80FF, 32'h00000012};
    for (int i = 0; i < 5; i++) begin
      run_op(1'b1, 1'b0, f3[i], ad[i], 32'h0, 32'h80FF1234, 0, 0);
      checks++;
      if (ob_res !== exp[i]) begin
        errors++; $display("FAIL load_ext[%0d]: got %h expected %h", i, ob_res, exp[i]);
      end
    end
  endtask

  task automatic test_store();
    run_op(1'b0, 1'b1, MEM_BYT_B, 32'h101, 32'h000000AB, 32'h0, 0, 0);
    checks++;
    if ({ob_addr, ob_wdata, ob_wmask, ob_wr} !== {32'h100, 32'hABABABAB, 4'b0010, 1'b1}) begin
      errors++; $display("FAIL sb_req: addr=%h wdata=%h wmask=%b wr=%b expected 100/ABABABAB/0010/1",
                         ob_addr, ob_wdata, ob_wmask, ob_wr);
    end
    checks++;
    if ({ob_cyc, ob_res} !== {32'd2, 32'h0}) begin
      errors++; $display("FAIL sb_done: cyc=%0d res=%h expected 2/0", ob_cyc, ob_res);
    end
    run_op(1'b0, 1'b1, MEM_BYT_H, 32'h102, 32'h1234CDEF, 32'h0, 0, 0);
    checks++;
    if ({ob_addr, ob_wdata, ob_wmask} !== {32'h100, 32'hCDEFCDEF, 4'b1100}) begin
      errors++; $display("FAIL sh_req: addr=%h wdata=%h wmask=%b expected 100/CDEFCDEF/1100", ob_addr, ob_wdata, ob_wmask);
    end
    run_op(1'b0, 1'b1, MEM_BYT_W, 32'h204, 32'h11223344, 32'h0, 0, 0);
    checks++;
    if ({ob_addr, ob_wdata, ob_wmask} !== {32'h204, 32'h11223344, 4'hF}) begin
      errors++; $display("FAIL sw_req: addr=%h wdata=%h wmask=%b expected 204/11223344/1111", ob_addr, ob_wdata, ob_wmask);
    end
    run_op(1'b1, 1'b1, MEM_BYT_W, 32'h308, 32'h55667788, 32'hAAAAAAAA, 0, 0);
    checks++;
    if ({ob_wr, ob_wmask, ob_cyc, ob_res} !== {1'b1, 4'hF, 32'd2, 32'h0}) begin
      errors++; $display("FAIL both_en: wr=%b wmask=%b cyc=%0d res=%h expected 1/1111/2/0", ob_wr, ob_wmask, ob_cyc, ob_res);
    end
  endtask

  task automatic test_nonmem();
    run_op(1'b0, 1'b0, MEM_BYT_W, 32'h12345678, 32'hFFFFFFFF, 32'h0, 0, 0);
    checks++;
    if ({ob_cyc, ob_reqvcnt, ob_res} !== {32'd1, 32'd0, 32'h0}) begin
      errors++; $display("FAIL nonmem: cyc=%0d reqs=%0d res=%h expected 1/0/0", ob_cyc, ob_reqvcnt, ob_res);
    end
  endtask

  task automatic test_back_to_back_stall();
    run_op(1'b1, 1'b0, MEM_BYT_W, 32'h100, 32'h0, 32'h0BADF00D, 3, 2);
    checks++;
    if (ob_cyc !== 6) begin errors++; $display("FAIL stall_latency: got %0d expected 6", ob_cyc); end
    checks++;
    if ({ob_reqvcnt, ob_nreq, ob_vcnt} !== {32'd4, 32'd1, 32'd3}) begin
      errors++; $display("FAIL stall_counts: reqcyc=%0d nreq=%0d validcyc=%0d expected 4/1/3", ob_reqvcnt, ob_nreq, ob_vcnt);
    end
    checks++;
    if ({ob_stable, ob_res} !== {1'b1, 32'h0BADF00D}) begin
      errors++; $display("FAIL stall_hold: stable=%b res=%h expected 1/0BADF00D", ob_stable, ob_res);
    end
    run_op(1'b1, 1'b0, MEM_BYT_HU, 32'h102, 32'h0, 32'h80FF1234, 0, 0);
    checks++;
    if ({ob_cyc, ob_res} !== {32'd3, 32'h000080FF}) begin
      errors++; $display("FAIL b2b_next: cyc=%0d res=%h expected 3/000080FF", ob_cyc, ob_res);
    end
  endtask

  task automatic test_reset_midwait();
    logic got = 1'b0;
    @(negedge clk);
    sys_valid_i = 1'b1; rd_en = 1'b1; wr_en = 1'b0; byt = MEM_BYT_W; exu_res = 32'h100; rs2 = '0;
    @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      sys_valid_i = 1'b0; rd_en = 1'b0;
      req_ready = req_valid;
      if (rsp_ready) begin got = 1'b1; break; end
    end
    req_ready = 1'b0;
    checks++;
    if (got !== 1'b1) begin errors++; $display("FAIL rst_reach_wait: got %b expected 1", got); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sys_ready_o, req_valid, rsp_ready, sys_valid_o, lsu_res, req_addr, req_wmask} !== {4'b1000, 68'd0}) begin
      errors++; $display("FAIL rst_midwait: ctrl=%b res=%h addr=%h wmask=%b expected 1000/0/0/0",
                         {sys_ready_o, req_valid, rsp_ready, sys_valid_o}, lsu_res, req_addr, req_wmask);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b1, 1'b0, MEM_BYT_W, 32'h200, 32'h0, 32'h12345678, 0, 0);
    checks++;
    if ({ob_timeout, ob_cyc, ob_res, ob_nreq} !== {1'b0, 32'd3, 32'h12345678, 32'd1}) begin
      errors++; $display("FAIL rst_next_lw: timeout=%b cyc=%0d res=%h nreq=%0d expected 0/3/12345678/1",
                         ob_timeout, ob_cyc, ob_res, ob_nreq);
    end
  endtask

`ifdef LSU_MISALIGN_CHECK_EN
  task automatic test_misalign();
    run_op(1'b1, 1'b0, MEM_BYT_W, 32'h102, 32'h0, 32'hDEADBEEF, 0, 0);
    checks++;
    if ({ob_reqvcnt, ob_cyc, ob_res, ob_mis} !== {32'd0, 32'd1, 32'h0, 1'b1}) begin
      errors++; $display("FAIL misalign_lw: reqs=%0d cyc=%0d res=%h mis=%b expected 0/1/0/1", ob_reqvcnt, ob_cyc, ob_res, ob_mis);
    end
    run_op(1'b0, 1'b1, MEM_BYT_H, 32'h103, 32'h1111, 32'h0, 0, 0);
    checks++;
    if ({ob_reqvcnt, ob_mis} !== {32'd0, 1'b1}) begin
      errors++; $display("FAIL misalign_sh: reqs=%0d mis=%b expected 0/1", ob_reqvcnt, ob_mis);
    end
    run_op(1'b1, 1'b0, MEM_BYT_B, 32'h103, 32'h0, 32'h80FF1234, 0, 0);
    checks++;
    if ({ob_mis, ob_res, ob_cyc} !== {1'b0, 32'hFFFFFF80, 32'd3}) begin
      errors++; $display("FAIL misalign_lb_ok: mis=%b res=%h cyc=%0d expected 0/FFFFFF80/3", ob_mis, ob_res, ob_cyc);
    end
  endtask
`else
  task automatic test_misalign();
    run_op(1'b1, 1'b0, MEM_BYT_W, 32'h102, 32'h0, 32'hCAFEF00D, 0, 0);
    checks++;
    if ({ob_addr, ob_res, ob_cyc} !== {32'h100, 32'hCAFEF00D, 32'd3}) begin
      errors++; $display("FAIL word_ignore_lo: addr=%h res=%h cyc=%0d expected 100/CAFEF00D/3", ob_addr, ob_res, ob_cyc);
    end
    run_op(1'b1, 1'b0, MEM_BYT_H, 32'h103, 32'h0, 32'h80FF1234, 0, 0);
    checks++;
    if (ob_res !== 32'hFFFF80FF) begin
      errors++; $display("FAIL half_ignore_b0: got %h expected FFFF80FF", ob_res);
    end
  endtask
`endif

  initial begin
    sys_valid_i = 1'b0; rd_en = 1'b0; wr_en = 1'b0; byt = 3'b000; exu_res = '0; rs2 = '0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0; sys_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_lw();
    test_load_extend();
    test_store();
    test_nonmem();
    test_back_to_back_stall();
    test_reset_midwait();
    test_misalign();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
